// File: rtl/fir_decim_fifo_pkg.sv
// Shared constants for the FIR filter and its decimating output buffer.
// The FIR and this block take their tap count from the same constant, so the
// warm-up length always follows the filter length.
package fir_decim_fifo_pkg;

  // FIR geometry shared with the upstream filter
  localparam int FIR_TAPS   = 21;
  localparam int DATA_W_DEF = 12;

  // Samples before the FIR delay line holds only real data
  localparam int WARMUP_DEF = FIR_TAPS - 1;

  // Buffer / decimation defaults
  localparam int DECIM_DEF  = 4;
  localparam int DEPTH_DEF  = 8;

  // Warm-up / decimation controller states
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } dec_state_e;

  // Width that can hold 0..n (never narrower than 1 bit)
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty flag and fill level.
// The head entry is presented combinationally from storage, so the read
// data holds steady for as long as the head is not popped. A write to a
// full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q;
  logic              rd_ok;
  logic              wr_ok;

  // A pop needs data; a push into a full FIFO needs a same-cycle pop
  assign full  = (level_q == LVL_W'(DEPTH));
  assign rd_ok = rd_en && !empty_q;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Next fill level from the accepted push/pop pair
  always_comb begin
    level_d = level_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers, level and empty flag; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      empty_q <= (level_d == '0);
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  // When full with a same-cycle read, the write lands in the slot being
  // vacated, which becomes the new tail once rd_ptr advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign empty   = empty_q;

endmodule

// File: rtl/fir_decim_fifo.sv
// Output stage of the FIR: drops the start-up transient, keeps one sample
// in DECIM, and buffers kept samples for a valid/ready consumer.
// Samples pass through bit-exact; no rounding or saturation.
module fir_decim_fifo
  import fir_decim_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DECIM  = DECIM_DEF,
  parameter int WARMUP = WARMUP_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int WC_W = cnt_w(WARMUP);
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  dec_state_e        state_q;
  logic [WC_W-1:0]   warm_cnt_q;
  logic [PH_W-1:0]   phase_q;
  logic              ovf_q;

  logic              keep;
  logic              rd;
  logic              wr;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  // A sample is kept on a strobe in RUN at decimation phase zero
  assign keep = din_en && (state_q == ST_RUN) && (phase_q == '0);

  // Consumer handshake; a ready with nothing valid is ignored
  assign rd   = m_valid && m_ready;

  // Full FIFO accepts a kept sample only if the head leaves this cycle
  assign wr   = keep && (!fifo_full || rd);
  assign drop = keep && fifo_full && !rd;

  // Warm-up count then free-running decimation phase; RUN exits only on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      warm_cnt_q <= '0;
      phase_q    <= '0;
    end else if (din_en) begin
      case (state_q)
        ST_WARMUP: begin
          warm_cnt_q <= warm_cnt_q + 1'b1;
          // The strobe that completes the warm-up is itself discarded
          if (warm_cnt_q == WC_W'(WARMUP - 1)) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (phase_q == PH_W'(DECIM - 1)) phase_q <= '0;
          else                             phase_q <= phase_q + 1'b1;
        end
        default: state_q <= ST_WARMUP;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (din),
    .rd_en   (rd),
    .rd_data (m_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: default instance plus a DECIM=1/WARMUP=0 one,
// both driven by the same pins and compared every cycle to a queue model.
module tb_fir_decim_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        din_en;
  logic        m_ready;
  logic        ovf_clr;

  logic [11:0] m0_data, m1_data;
  logic        m0_valid, m1_valid;
  logic [3:0]  lvl0, lvl1;
  logic        ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  // Reference model state per instance
  logic [11:0] mq [2][$];
  int          scnt [2];
  logic        movf [2];
  logic [11:0] got [$];

  always #5 clk = ~clk;

  fir_decim_fifo u0 (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .m_data(m0_data), .m_valid(m0_valid), .m_ready(m_ready),
    .level(lvl0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  fir_decim_fifo #(.DECIM(1), .WARMUP(0)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .m_data(m1_data), .m_valid(m1_valid), .m_ready(m_ready),
    .level(lvl1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: strobe index decides keep; a bounded queue decides accept/drop
  task automatic model_upd(input int k);
    int   w, dc;
    logic rd, keep, full;
    w  = (k == 0) ? 20 : 0;
    dc = (k == 0) ? 4 : 1;
    if (rst) begin
      mq[k].delete();
      scnt[k] = 0;
      movf[k] = 1'b0;
      return;
    end
    rd   = (mq[k].size() != 0) && m_ready;
    keep = din_en && (scnt[k] >= w) && (((scnt[k] - w) % dc) == 0);
    if (din_en) scnt[k]++;
    full = (mq[k].size() == 8);
    if (rd) void'(mq[k].pop_front());
    if (keep && full && !rd) movf[k] = 1'b1;
    else if (ovf_clr)        movf[k] = 1'b0;
    if (keep && !(full && !rd)) mq[k].push_back(din);
  endtask

  task automatic check_all();
    chk("u0_valid", m0_valid, mq[0].size() != 0);
    chk("u0_level", lvl0, mq[0].size());
    chk("u0_ovf",   ovf0, movf[0]);
    if (mq[0].size() != 0) chk("u0_data", m0_data, mq[0][0]);
    chk("u1_valid", m1_valid, mq[1].size() != 0);
    chk("u1_level", lvl1, mq[1].size());
    chk("u1_ovf",   ovf1, movf[1]);
    if (mq[1].size() != 0) chk("u1_data", m1_data, mq[1][0]);
  endtask

  // One clock: drive, take the edge, advance model, check 1 time unit later
  task automatic step(input logic en, input logic [11:0] d, input logic rdy,
                      input logic clr, input logic r);
    din = d; din_en = en; m_ready = rdy; ovf_clr = clr; rst = r;
    if (!r && m0_valid && rdy) got.push_back(m0_data);
    @(posedge clk);
    model_upd(0);
    model_upd(1);
    #1;
    check_all();
  endtask

  initial begin
    logic [11:0] x;
    din = '0; din_en = 0; m_ready = 0; ovf_clr = 0; rst = 1;

    // Reset state
    step(0, 12'd0, 0, 0, 1);
    chk("rst_valid", m0_valid, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_ovf",   ovf0, 0);
    chk("rst_data",  m0_data, 0);

    // 1: continuous stream, always ready
    for (int n = 0; n < 60; n++) begin
      step(1, 12'(n), 1, 0, 0);
      if (n < 20) chk("t1_warm_valid", m0_valid, 0);
      if (n == 20) begin
        chk("t1_first_valid", m0_valid, 1);
        chk("t1_first_data",  m0_data, 20);
      end
      chk("t1_level_max", lvl0 <= 1, 1);
    end

    // 2: overflow with consumer stalled
    step(0, 12'd0, 0, 0, 1);
    for (int n = 0; n <= 52; n++) begin
      step(1, 12'(n), 0, 0, 0);
      if (n == 48) chk("t2_full", lvl0, 8);
    end
    chk("t2_ovf",   ovf0, 1);
    chk("t2_level", lvl0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", m0_data, 20 + 4 * i);
      step(0, 12'd0, 1, 0, 0);
    end
    chk("t2_empty", m0_valid, 0);
    step(0, 12'd0, 1, 1, 0);
    chk("t2_ovf_clr", ovf0, 0);

    // 3: full plus read in the same cycle as sample 52
    step(0, 12'd0, 0, 0, 1);
    for (int n = 0; n <= 51; n++) step(1, 12'(n), 0, 0, 0);
    step(1, 12'd52, 1, 0, 0);
    chk("t3_level", lvl0, 8);
    chk("t3_ovf",   ovf0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", m0_data, 24 + 4 * i);
      step(0, 12'd0, 1, 0, 0);
    end

    // 4: strobe gaps with garbage on idle cycles
    step(0, 12'd0, 0, 0, 1);
    got.delete();
    for (int n = 0; n < 40; n++) begin
      step(1, 12'(n), 1, 0, 0);
      step(0, 12'($urandom), 1, 0, 0);
    end
    chk("t4_count", got.size() >= 4, 1);
    foreach (got[i]) chk("t4_kept", got[i], 20 + 4 * i);

    // 5: reset in the middle of a run
    step(0, 12'd0, 0, 0, 1);
    for (int n = 0; n <= 36; n++) step(1, 12'(n), 0, 0, 0);
    chk("t5_level5", lvl0, 5);
    step(0, 12'd0, 0, 0, 1);
    chk("t5_valid", m0_valid, 0);
    chk("t5_level", lvl0, 0);
    chk("t5_ovf",   ovf0, 0);
    for (int n = 0; n < 20; n++) begin
      step(1, 12'($urandom), 0, 0, 0);
      chk("t5_warm", m0_valid, 0);
    end
    x = 12'($urandom);
    step(1, x, 0, 0, 0);
    chk("t5_first_valid", m0_valid, 1);
    chk("t5_first_data",  m0_data, x);

    // 6: DECIM=1, WARMUP=0 with extreme signed values (-2048, 2047, -1)
    step(0, 12'd0, 0, 0, 1);
    step(1, 12'h800, 1, 0, 0);
    chk("t6_neg_min", m1_data, 12'h800);
    step(1, 12'h7FF, 1, 0, 0);
    chk("t6_pos_max", m1_data, 12'h7FF);
    step(1, 12'hFFF, 1, 0, 0);
    chk("t6_neg_one", m1_data, 12'hFFF);

    // 7: random traffic, clears and occasional resets
    for (int n = 0; n < 500; n++)
      step(1'($urandom), 12'($urandom), ($urandom % 3) != 0,
           ($urandom % 8) == 0, ($urandom % 150) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
